// File: rtl/contactor_sequencer.sv
// Contactor sequencer: serialises requested contactor transitions in round-robin order,
// confirms each against router feedback within a timeout and enforces a closed-count ceiling.
module contactor_sequencer #(
    parameter int N_CONT         = 21,
    parameter int MAX_CLOSED     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CONT-1:0]     spi_requests,
    input  logic [2*N_CONT-1:0]   router_feedback,
    input  logic                  shutdown_req,
    input  logic                  clear_errors,
    output logic [N_CONT-1:0]     contactor_cmd,
    output logic [N_CONT-1:0]     contactor_status,
    output logic                  feedback_timeout_error,
    output logic                  invalid_request,
    output logic                  busy
);
    localparam int PTR_W = $clog2(N_CONT);
    localparam int CNT_W = $clog2(N_CONT + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRIVE,
        S_WAIT_FB,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [N_CONT-1:0]   cmd_q, cmd_d;
    logic [N_CONT-1:0]   status_q, status_d;
    logic                tmo_err_q, tmo_err_d;
    logic                invalid_q, invalid_d;
    logic [N_CONT-1:0]   req_meta_q, req_meta_d;
    logic [N_CONT-1:0]   req_sync_q, req_sync_d;

    logic [N_CONT-1:0]   req_e;
    logic [N_CONT-1:0]   pending;
    logic [N_CONT-1:0]   fb_closed;
    logic [N_CONT-1:0]   fb_open;
    logic [CNT_W-1:0]    closed_cnt;
    logic [PTR_W-1:0]    ptr_inc;
    logic                fb_match;

    for (genvar gi = 0; gi < N_CONT; gi++) begin : g_fb
        assign fb_closed[gi] = (router_feedback[2*gi +: 2] == 2'b10);
        assign fb_open[gi]   = (router_feedback[2*gi +: 2] == 2'b01);
    end

    assign req_meta_d = spi_requests;
    assign req_sync_d = req_meta_q;
    // Shutdown masks every request, so nothing can be seen as wanting to close.
    assign req_e   = req_sync_q & ~{N_CONT{shutdown_req}};
    assign pending = req_e ^ cmd_q;
    assign ptr_inc = (ptr_q == PTR_W'(N_CONT - 1)) ? '0 : ptr_q + 1'b1;
    assign fb_match = cmd_q[ptr_q] ? fb_closed[ptr_q] : fb_open[ptr_q];
    assign status_d = cmd_q & fb_closed;

    always_comb begin
        closed_cnt = '0;
        for (int i = 0; i < N_CONT; i++) begin
            closed_cnt = closed_cnt + CNT_W'(cmd_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        cmd_d     = cmd_q;
        tmo_err_d = tmo_err_q;
        invalid_d = invalid_q;

        if (clear_errors && state_q != S_ERROR) begin
            invalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (|pending) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!pending[ptr_q]) begin
                    ptr_d = ptr_inc;
                    if (!(|pending)) begin
                        state_d = S_IDLE;
                    end
                end else if (!req_e[ptr_q] || closed_cnt < CNT_W'(MAX_CLOSED)) begin
                    state_d = S_DRIVE;
                end else begin
                    // Refused close stays pending and is retried on a later lap.
                    invalid_d = 1'b1;
                    ptr_d     = ptr_inc;
                end
            end
            S_DRIVE: begin
                cmd_d[ptr_q] = req_e[ptr_q];
                timer_d      = '0;
                state_d      = S_WAIT_FB;
            end
            S_WAIT_FB: begin
                timer_d = timer_q + 1'b1;
                if (fb_match) begin
                    ptr_d   = ptr_inc;
                    state_d = S_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_err_d = 1'b1;
                    cmd_d     = '0;
                    state_d   = S_ERROR;
                end
            end
            S_ERROR: begin
                cmd_d = '0;
                if (clear_errors && !shutdown_req) begin
                    tmo_err_d = 1'b0;
                    invalid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (shutdown_req && state_q != S_ERROR) begin
            cmd_d   = '0;
            state_d = S_IDLE;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            timer_q    <= '0;
            cmd_q      <= '0;
            status_q   <= '0;
            tmo_err_q  <= 1'b0;
            invalid_q  <= 1'b0;
            req_meta_q <= '0;
            req_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            cmd_q      <= cmd_d;
            status_q   <= status_d;
            tmo_err_q  <= tmo_err_d;
            invalid_q  <= invalid_d;
            req_meta_q <= req_meta_d;
            req_sync_q <= req_sync_d;
        end
    end

    assign contactor_cmd          = cmd_q;
    assign contactor_status       = status_q;
    assign feedback_timeout_error = tmo_err_q;
    assign invalid_request        = invalid_q;
    assign busy                   = (state_q != S_IDLE);

endmodule
